// File: rtl/layered_rgb_mux_if.sv
// Pixel-path bundle between the object drawers, the layered RGB mux and the VGA controller.
// master = drawer/frame side, slave = the mux.
interface layered_rgb_mux_if #(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned RGB_W      = 8
);
    logic [NUM_LAYERS-1:0]       layer_dr;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0]            bg_rgb;
    logic [10:0]                 pixelX;
    logic                        startOfFrame;
    logic                        endOfGame;
    logic                        overlay_dr;
    logic [RGB_W-1:0]            overlay_rgb;
    logic                        mask_we;
    logic [NUM_LAYERS-1:0]       mask_in;
    logic [RGB_W-1:0]            RGBOut;
    logic [3:0]                  top_layer;
    logic                        fade_done;

    modport master (
        output layer_dr, layer_rgb, bg_rgb, pixelX, startOfFrame, endOfGame,
               overlay_dr, overlay_rgb, mask_we, mask_in,
        input  RGBOut, top_layer, fade_done
    );

    modport slave (
        input  layer_dr, layer_rgb, bg_rgb, pixelX, startOfFrame, endOfGame,
               overlay_dr, overlay_rgb, mask_we, mask_in,
        output RGBOut, top_layer, fade_done
    );
endinterface

// File: rtl/layered_rgb_mux.sv
// Prioritised layer mux with 2-stage pipeline and end-of-game play-area fade.
// Optional sticky layer-0 collision flag when COLLISION_LATCH_EN is defined.
module layered_rgb_mux #(
    parameter int unsigned NUM_LAYERS  = 8,
    parameter int unsigned RGB_W       = 8,
    parameter int unsigned X_SPLIT     = 86,
    parameter int unsigned FADE_FRAMES = 15,
    parameter int unsigned MAX_FADE    = 3
) (
    input  logic clk,
    input  logic resetN,
`ifdef COLLISION_LATCH_EN
    output logic collision,
`endif
    layered_rgb_mux_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFading, StDark} fade_state_e;

    // top_layer is 4 bits wide, so background index aliases to 0 when NUM_LAYERS = 16
    localparam logic [3:0]  BG_IDX    = 4'(NUM_LAYERS);
    localparam logic [10:0] X_SPLIT_L = 11'(X_SPLIT);
    localparam logic [7:0]  FADE_LAST = 8'(FADE_FRAMES - 1);
    localparam logic [3:0]  MAX_LVL   = 4'(MAX_FADE);

    logic [NUM_LAYERS-1:0] mask_q;
    logic [NUM_LAYERS-1:0] eff_req;
    logic [3:0]            win_idx;
    logic [RGB_W-1:0]      win_rgb;

    logic [3:0]       s1_idx_q;
    logic [RGB_W-1:0] s1_rgb_q;
    logic             s1_in_fade_q;
    logic             s1_ovl_dr_q;
    logic [RGB_W-1:0] s1_ovl_rgb_q;

    logic [RGB_W-1:0] s2_rgb;
    logic [RGB_W-1:0] rgb_q;
    logic [3:0]       top_q;

    fade_state_e state_q;
    logic [3:0]  level_q;
    logic [7:0]  frame_cnt_q;

    function automatic logic [7:0] dim(input logic [7:0] c, input logic [3:0] lvl);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[7:5] >> lvl;
        g = c[4:2] >> lvl;
        b = c[1:0] >> lvl;
        return {r, g, b};
    endfunction

    // Descending scan so the lowest-index request wins.
    always_comb begin
        eff_req = bus.layer_dr & mask_q;
        win_idx = BG_IDX;
        win_rgb = bus.bg_rgb;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (eff_req[i]) begin
                win_idx = 4'(i);
                win_rgb = bus.layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mask_q <= '1;
        end else if (bus.mask_we) begin
            mask_q <= bus.mask_in;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_idx_q     <= '0;
            s1_rgb_q     <= '0;
            s1_in_fade_q <= 1'b0;
            s1_ovl_dr_q  <= 1'b0;
            s1_ovl_rgb_q <= '0;
        end else begin
            s1_idx_q     <= win_idx;
            s1_rgb_q     <= win_rgb;
            s1_in_fade_q <= bus.pixelX > X_SPLIT_L;
            s1_ovl_dr_q  <= bus.overlay_dr;
            s1_ovl_rgb_q <= bus.overlay_rgb;
        end
    end

    always_comb begin
        s2_rgb = s1_rgb_q;
        if (s1_in_fade_q && state_q != StIdle) begin
            s2_rgb = s1_ovl_dr_q ? s1_ovl_rgb_q : dim(s1_rgb_q, level_q);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q <= '0;
            top_q <= BG_IDX;
        end else begin
            rgb_q <= s2_rgb;
            top_q <= s1_idx_q;
        end
    end

    // Leaving the game-over condition is immediate; every other move waits for a frame edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StIdle;
            level_q     <= '0;
            frame_cnt_q <= '0;
        end else if (!bus.endOfGame) begin
            state_q     <= StIdle;
            level_q     <= '0;
            frame_cnt_q <= '0;
        end else if (bus.startOfFrame) begin
            unique case (state_q)
                StIdle: begin
                    state_q     <= (MAX_LVL <= 4'd1) ? StDark : StFading;
                    level_q     <= 4'd1;
                    frame_cnt_q <= '0;
                end
                StFading: begin
                    if (frame_cnt_q == FADE_LAST) begin
                        frame_cnt_q <= '0;
                        level_q     <= level_q + 4'd1;
                        if (level_q + 4'd1 >= MAX_LVL) begin
                            state_q <= StDark;
                        end
                    end else begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end
                end
                StDark: begin
                    state_q <= StDark;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.RGBOut    = rgb_q;
    assign bus.top_layer = top_q;
    assign bus.fade_done = (state_q == StDark);

`ifdef COLLISION_LATCH_EN
    logic collision_q;

    // A new overlap beats the frame-start clear.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision_q <= 1'b0;
        end else if (eff_req[0] && |eff_req[NUM_LAYERS-1:1]) begin
            collision_q <= 1'b1;
        end else if (bus.startOfFrame) begin
            collision_q <= 1'b0;
        end
    end

    assign collision = collision_q;
`endif
endmodule

// File: tb/tb_layered_rgb_mux.sv
// Self-checking bench for layered_rgb_mux: scoreboard of expected pixels at 2-clock latency.
module tb_layered_rgb_mux;
    localparam int unsigned NL = 8;

    typedef struct {
        logic [7:0] rgb;
        logic [3:0] top;
        bit         chk;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    layered_rgb_mux_if #(.NUM_LAYERS(NL), .RGB_W(8)) bus ();
`ifdef COLLISION_LATCH_EN
    logic collision;
`endif

    layered_rgb_mux #(
        .NUM_LAYERS (NL),
        .RGB_W      (8),
        .X_SPLIT    (86),
        .FADE_FRAMES(2),
        .MAX_FADE   (3)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
`ifdef COLLISION_LATCH_EN
        .collision(collision),
`endif
        .bus      (bus)
    );

    logic [7:0] lc [NL];
    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Compare the pixel pushed two steps ago, push this step's expectation, advance one clock.
    task automatic step(input logic [7:0] rgb, input logic [3:0] top, input bit chk,
                        input string nm);
        exp_t e;
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                n_checks++;
                if (bus.RGBOut !== e.rgb || bus.top_layer !== e.top)
                    $display("FAIL %s: RGBOut=%h top_layer=%0d, expected %h/%0d",
                             e.nm, bus.RGBOut, bus.top_layer, e.rgb, e.top);
                else
                    n_pass++;
            end
        end
        e.rgb = rgb;
        e.top = top;
        e.chk = chk;
        e.nm  = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset;
        lc[0] = 8'hFF; lc[1] = 8'h1C; lc[2] = 8'hE0; lc[3] = 8'h03;
        lc[4] = 8'h44; lc[5] = 8'h55; lc[6] = 8'h66; lc[7] = 8'h77;
        for (int i = 0; i < int'(NL); i++) bus.layer_rgb[i*8 +: 8] = lc[i];
        bus.layer_dr = '0; bus.bg_rgb = 8'h49; bus.pixelX = 11'd50;
        bus.startOfFrame = 1'b0; bus.endOfGame = 1'b0;
        bus.overlay_dr = 1'b0; bus.overlay_rgb = 8'h00;
        bus.mask_we = 1'b0; bus.mask_in = '1;
        resetN = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.RGBOut !== 8'h00 || bus.top_layer !== 4'd8 || bus.fade_done !== 1'b0)
            $display("FAIL reset_outputs: RGBOut=%h top=%0d fade_done=%b, expected 00/8/0",
                     bus.RGBOut, bus.top_layer, bus.fade_done);
        else n_pass++;
`ifdef COLLISION_LATCH_EN
        n_checks++;
        if (collision !== 1'b0) $display("FAIL reset_collision: got %b expected 0", collision);
        else n_pass++;
`endif
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_priority;
        bus.pixelX = 11'd50;
        bus.layer_dr = 8'h06; step(8'h1C, 4'd1, 1, "prio_06");
        bus.layer_dr = 8'h00; step(8'h49, 4'd8, 1, "prio_bg_after");
        bus.layer_dr = 8'h80; step(8'h77, 4'd7, 1, "prio_80");
        bus.layer_dr = 8'hFF; step(8'hFF, 4'd0, 1, "prio_ff");
        bus.layer_dr = 8'h18; step(8'h03, 4'd3, 1, "prio_18");
    endtask

    task automatic test_mask;
        bus.layer_dr = 8'h00; step(8'h49, 4'd8, 1, "mask_bg");
        bus.mask_we = 1'b1; bus.mask_in = 8'hFD; bus.layer_dr = 8'h02;
        step(8'h1C, 4'd1, 1, "mask_old_same_cycle");
        bus.mask_we = 1'b0;
        step(8'h49, 4'd8, 1, "mask_blocked");
        bus.layer_dr = 8'h06; step(8'hE0, 4'd2, 1, "mask_next_layer");
        bus.mask_we = 1'b1; bus.mask_in = 8'hFF; bus.layer_dr = 8'h00;
        step(8'h49, 4'd8, 1, "mask_restore");
        bus.mask_we = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] dr;
        logic [7:0] er;
        logic [3:0] et;
        for (int k = 0; k < 16; k++) begin
            dr = 8'($urandom_range(0, 255));
            er = 8'h49;
            et = 4'd8;
            for (int j = int'(NL) - 1; j >= 0; j--) begin
                if (dr[j]) begin
                    er = lc[j];
                    et = 4'(j);
                end
            end
            bus.layer_dr = dr;
            bus.pixelX = 11'($urandom_range(0, 639));
            step(er, et, 1, "b2b_random");
        end
    endtask

    task automatic sof_step(input logic [7:0] rgb, input string nm);
        bus.startOfFrame = 1'b1;
        step(rgb, 4'd0, 1, nm);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic test_fade;
        bus.layer_dr = 8'h01; bus.pixelX = 11'd200; bus.overlay_dr = 1'b0;
        bus.endOfGame = 1'b1;
        step(8'hFF, 4'd0, 1, "fade_idle_no_sof");
        step(8'hFF, 4'd0, 1, "fade_idle_no_sof");
        sof_step(8'h6D, "fade_l1");
        n_checks++;
        if (bus.fade_done !== 1'b0) $display("FAIL fade_done_l1: got %b expected 0", bus.fade_done);
        else n_pass++;
        step(8'h6D, 4'd0, 1, "fade_l1_hold");
        sof_step(8'h6D, "fade_l1_cnt");
        step(8'h6D, 4'd0, 1, "fade_l1_hold2");
        sof_step(8'h24, "fade_l2");
        step(8'h24, 4'd0, 1, "fade_l2_hold");
        sof_step(8'h24, "fade_l2_cnt");
        n_checks++;
        if (bus.fade_done !== 1'b0) $display("FAIL fade_done_l2: got %b expected 0", bus.fade_done);
        else n_pass++;
        sof_step(8'h00, "fade_l3_dark");
        step(8'h00, 4'd0, 1, "fade_dark_hold");
        n_checks++;
        if (bus.fade_done !== 1'b1) $display("FAIL fade_done_dark: got %b expected 1", bus.fade_done);
        else n_pass++;
    endtask

    task automatic test_dark_hud;
        bus.pixelX = 11'd50;  step(8'hFF, 4'd0, 1, "dark_hud_50");
        bus.pixelX = 11'd86;  step(8'hFF, 4'd0, 1, "dark_boundary_86");
        bus.pixelX = 11'd87;  step(8'h00, 4'd0, 1, "dark_boundary_87");
        bus.pixelX = 11'd200; bus.overlay_dr = 1'b1; bus.overlay_rgb = 8'hE0;
        step(8'hE0, 4'd0, 1, "dark_overlay");
        bus.pixelX = 11'd50;  step(8'hFF, 4'd0, 1, "overlay_outside_region");
        bus.overlay_dr = 1'b0; bus.pixelX = 11'd200;
        step(8'h00, 4'd0, 1, "dark_no_overlay");
    endtask

    task automatic test_abort;
        bus.endOfGame = 1'b0; step(8'hFF, 4'd0, 1, "abort_from_dark");
        n_checks++;
        if (bus.fade_done !== 1'b0) $display("FAIL abort_fade_done: got %b expected 0", bus.fade_done);
        else n_pass++;
        bus.endOfGame = 1'b1;
        sof_step(8'h6D, "refade_l1");
        step(8'h6D, 4'd0, 1, "refade_hold");
        bus.endOfGame = 1'b0; step(8'hFF, 4'd0, 1, "abort_mid_fading");
        step(8'hFF, 4'd0, 1, "abort_idle_hold");
    endtask

    task automatic test_reset_mid_fade;
        bus.endOfGame = 1'b1;
        sof_step(8'h6D, "pre_reset_l1");
        step(8'h6D, 4'd0, 1, "pre_reset_hold");
        #2 resetN = 1'b0;
        #1;
        n_checks++;
        if (bus.RGBOut !== 8'h00 || bus.top_layer !== 4'd8 || bus.fade_done !== 1'b0)
            $display("FAIL reset_mid_fade: RGBOut=%h top=%0d fade_done=%b, expected 00/8/0",
                     bus.RGBOut, bus.top_layer, bus.fade_done);
        else n_pass++;
        exp_q.delete();
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        // endOfGame still high but no frame edge yet: play area must be undimmed
        step(8'hFF, 4'd0, 1, "post_reset_idle");
        step(8'hFF, 4'd0, 1, "post_reset_idle");
        step(8'hFF, 4'd0, 1, "post_reset_idle");
        bus.endOfGame = 1'b0;
    endtask

`ifdef COLLISION_LATCH_EN
    task automatic test_collision;
        bus.pixelX = 11'd50;
        bus.layer_dr = 8'h01; step(8'hFF, 4'd0, 1, "coll_l0_only");
        n_checks++;
        if (collision !== 1'b0) $display("FAIL coll_single: got %b expected 0", collision);
        else n_pass++;
        bus.layer_dr = 8'h05; step(8'hFF, 4'd0, 1, "coll_overlap");
        n_checks++;
        if (collision !== 1'b1) $display("FAIL coll_set: got %b expected 1", collision);
        else n_pass++;
        bus.layer_dr = 8'h00; step(8'h49, 4'd8, 1, "coll_hold"); step(8'h49, 4'd8, 1, "coll_hold");
        n_checks++;
        if (collision !== 1'b1) $display("FAIL coll_sticky: got %b expected 1", collision);
        else n_pass++;
        bus.startOfFrame = 1'b1; step(8'h49, 4'd8, 1, "coll_sof"); bus.startOfFrame = 1'b0;
        n_checks++;
        if (collision !== 1'b0) $display("FAIL coll_clear: got %b expected 0", collision);
        else n_pass++;
        bus.layer_dr = 8'h05; bus.startOfFrame = 1'b1;
        step(8'hFF, 4'd0, 1, "coll_set_vs_sof");
        bus.startOfFrame = 1'b0; bus.layer_dr = 8'h00;
        n_checks++;
        if (collision !== 1'b1) $display("FAIL coll_set_wins: got %b expected 1", collision);
        else n_pass++;
        bus.mask_we = 1'b1; bus.mask_in = 8'hFB; bus.startOfFrame = 1'b1;
        step(8'h49, 4'd8, 1, "coll_clear2");
        bus.mask_we = 1'b0; bus.startOfFrame = 1'b0; bus.layer_dr = 8'h05;
        step(8'hFF, 4'd0, 1, "coll_masked");
        n_checks++;
        if (collision !== 1'b0) $display("FAIL coll_masked: got %b expected 0", collision);
        else n_pass++;
        bus.mask_we = 1'b1; bus.mask_in = 8'hFF; bus.layer_dr = 8'h00;
        step(8'h49, 4'd8, 1, "coll_unmask");
        bus.mask_we = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_priority();
        test_mask();
        test_back_to_back();
        test_fade();
        test_dark_hud();
        test_abort();
        test_reset_mid_fade();
`ifdef COLLISION_LATCH_EN
        test_collision();
`endif
        bus.layer_dr = 8'h00;
        step(8'h49, 4'd8, 0, "flush");
        step(8'h49, 4'd8, 0, "flush");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/layered_rgb_mux.md
Name: layered_rgb_mux

Overview:
- Parametrised successor to the fixed-priority object mux in the VGA path. Selects one of NUM_LAYERS drawing layers by index priority (layer 0 highest), with a background fallback and a runtime per-layer enable mask.
- Adds a 2-stage pipeline and an end-of-game fade state machine that dims the play area frame by frame, with a game-over overlay on top.
- Sits between the object drawers and the VGA controller.

Parameters:
- NUM_LAYERS, 8, number of prioritised drawing layers (2..16)
- RGB_W, 8, pixel width; RRRGGGBB format, fixed at 8
- X_SPLIT, 86, play-area boundary; fade applies where pixelX > X_SPLIT
- FADE_FRAMES, 15, frames per fade step (1..255)
- MAX_FADE, 3, fade level at which the play area is fully dark

Ports:
- clk  in  1  pixel clock
- resetN  in  1  reset
- layer_dr  in  NUM_LAYERS  per-layer drawing request; bit 0 is highest priority
- layer_rgb  in  NUM_LAYERS*RGB_W  layer colours; layer i at bits [i*8+7:i*8]
- bg_rgb  in  RGB_W  background colour, lowest priority
- pixelX  in  11  current pixel column
- startOfFrame  in  1  one-cycle pulse per frame
- endOfGame  in  1  level; high while the game is over
- overlay_dr  in  1  game-over overlay drawing request
- overlay_rgb  in  RGB_W  overlay colour
- mask_we  in  1  write strobe for the enable mask
- mask_in  in  NUM_LAYERS  new enable mask; 1 = layer enabled
- RGBOut  out  RGB_W  final pixel
- top_layer  out  4  index of the winning layer; NUM_LAYERS when background wins
- fade_done  out  1  high in DARK state

Behaviour:
- Reset: resetN is asynchronous, active-low; clock is clk. On reset: RGBOut=0, top_layer=NUM_LAYERS, fade_done=0, mask all ones, FSM=IDLE, fade level=0, frame counter=0, all pipeline registers 0.
- Mask:
  - On mask_we, mask<=mask_in; takes effect for pixels sampled on the following cycle.
  - Effective request is layer_dr & mask.
- Stage 1 (cycle+1):
  - Register the lowest-index effective request: its index and its colour.
  - If no request is active, register bg_rgb and index NUM_LAYERS.
  - Also register pixelX>X_SPLIT, overlay_dr and overlay_rgb.
- Stage 2 (cycle+2), drives RGBOut and top_layer:
  - Outside the fade region, or when FSM=IDLE: RGBOut = stage-1 colour.
  - In the region with FSM != IDLE: if overlay_dr is set, RGBOut = overlay_rgb at full brightness; otherwise RGBOut = dimmed colour.
- Total latency: 2 clocks from input to RGBOut, constant and independent of state.
- Dimming at level L: R[2:0]>>L, G[2:0]>>L, B[1:0]>>L, each field shifted independently with zero fill. At L>=3 the result is 0x00.
- Fade FSM, stepped on startOfFrame only (except return to IDLE):
  - IDLE: level 0. When endOfGame=1 at a startOfFrame, go to FADING with counter=0, level=1.
  - FADING: counter increments each startOfFrame. When counter reaches FADE_FRAMES-1, counter<=0 and level++. When level reaches MAX_FADE, go to DARK.
  - DARK: level=MAX_FADE, fade_done=1.
  - From any state, endOfGame=0 → IDLE, level=0, counter=0, on the next clock (not frame-gated).
- Level and state change only on frame boundaries (other than the IDLE return), so no tearing occurs mid-frame.
- Simultaneous mask_we and pixel: the pixel sampled in the same cycle uses the old mask.
- Reset mid-fade: everything returns to reset values immediately.

Optional Feature:
- Macro COLLISION_LATCH_EN.
- When defined:
  - Adds output collision (1 bit).
  - Set sticky when effective layer 0 and any other effective layer request are high in the same cycle.
  - Cleared on startOfFrame; a set in the same cycle as startOfFrame wins.
  - Registered: collision appears 1 clock after the overlapping pixel.
- When undefined: the port and its logic are absent.

Test Plan:
1. layer_dr=0x06, layer1=0x1C, layer2=0xE0 → RGBOut=0x1C, top_layer=1, exactly 2 clocks later.
2. layer_dr=0x00, bg_rgb=0x49 → RGBOut=0x49, top_layer=NUM_LAYERS. Then mask_we with mask_in=0xFD and layer_dr=0x02 → background shown from the next cycle.
3. FADE_FRAMES=2, endOfGame=1, layer colour 0xFF, pixelX=200:
   - Level 1 → RGBOut=0x6D (011_011_01).
   - After 2 more frames, level 2 → 0x24.
   - Then level 3 → 0x00 and fade_done=1.
4. In DARK, pixelX=50 with colour 0xFF → 0xFF (HUD unaffected). pixelX=200 with overlay_dr=1, overlay_rgb=0xE0 → 0xE0.
5. Drop endOfGame mid-FADING → next clock FSM=IDLE, colour 0xFF at pixelX=200 → 0xFF two cycles later.
6. (COLLISION_LATCH_EN) layer_dr=0x05 for one cycle → collision=1 next clock, held until startOfFrame, then 0.
